// File: rtl/jtag_tap_sequencer_if.sv
// rtl/jtag_tap_sequencer_if.sv - command/response channel bundle for jtag_tap_sequencer
interface jtag_tap_sequencer_if #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/jtag_tap_sequencer.sv
// rtl/jtag_tap_sequencer.sv - command-driven JTAG master: RESET/SHIFT_IR/SHIFT_DR/IDLE with TDO capture
module jtag_tap_sequencer #(
  parameter int MAX_LEN    = 64,
  parameter int LEN_W      = 7,
  parameter int TCK_DIV    = 2,
  parameter int RESET_TCKS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  jtag_tap_sequencer_if.slave bus,
  output logic                busy,
  output logic                tck_o,
  output logic                tms_o,
  output logic                tdi_o,
  output logic                trstn_o,
  input  logic                tdo
);
  localparam int               DIV_W     = $clog2(TCK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TCK_DIV - 1);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] RST_L     = LEN_W'(RESET_TCKS);
  localparam logic [LEN_W-1:0] RST_TOTAL = LEN_W'(RESET_TCKS + 1);
  localparam logic [1:0] OP_RESET = 2'b00, OP_IR = 2'b01, OP_DR = 2'b10, OP_IDLE = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SHIFT, S_POST, S_RESP} state_t;

  state_t             state_q, state_d, phase_next;
  logic [LEN_W-1:0]   cnt_q, cnt_d, len_q, len_d, len_eff, phase_total, pin_len;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               tck_q, tck_d, init_q, err_q, err_d, rsp_valid_q, rsp_valid_d;
  logic [1:0]         op_q, op_d, pin_op;
  logic [MAX_LEN-1:0] data_q, data_d, mask_q, mask_d, cap_q, cap_d;
  logic [2:0]         pins_q, pins_d;  // {trstn, tms, tdi}
  logic               accept, load;

  // Pin levels for period c of a phase; the TAP rests in Run-Test/Idle outside commands.
  function automatic logic [2:0] pin_bits(state_t st, logic [LEN_W-1:0] c, logic [1:0] op,
                                          logic [LEN_W-1:0] len, logic d0);
    pin_bits = 3'b100;
    case (st)
      S_PRE: begin
        case (op)
          OP_RESET: pin_bits = (c < RST_L) ? 3'b010 : 3'b100;
          OP_IR:    pin_bits = {1'b1, (c < LEN_W'(2)), 1'b0};
          OP_DR:    pin_bits = {1'b1, (c == '0), 1'b0};
          default:  pin_bits = 3'b100;
        endcase
      end
      S_SHIFT: pin_bits = {1'b1, (c == len - LEN_W'(1)), d0};
      S_POST:  pin_bits = {1'b1, (c == '0), 1'b0};
      default: pin_bits = 3'b100;
    endcase
  endfunction

  assign bus.cmd_ready = init_q && (state_q == S_IDLE) && !rsp_valid_q;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign len_eff       = (bus.cmd_len > MAX_LEN_L) ? MAX_LEN_L : bus.cmd_len;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    tck_d       = tck_q;
    op_d        = op_q;
    len_d       = len_q;
    data_d      = data_q;
    mask_d      = mask_q;
    cap_d       = cap_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    pins_d      = pins_q;
    load        = 1'b0;
    pin_op      = op_q;
    pin_len     = len_q;
    phase_total = LEN_W'(2);
    phase_next  = S_RESP;

    case (state_q)
      S_PRE: begin
        case (op_q)
          OP_RESET: phase_total = RST_TOTAL;
          OP_IDLE:  phase_total = len_q;
          OP_IR:    begin phase_total = LEN_W'(4); phase_next = S_SHIFT; end
          default:  begin phase_total = LEN_W'(3); phase_next = S_SHIFT; end
        endcase
      end
      S_SHIFT: begin phase_total = len_q; phase_next = S_POST; end
      default: ;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (rsp_valid_q && bus.rsp_ready) rsp_valid_d = 1'b0;
        if (accept) begin
          op_d    = bus.cmd_op;
          len_d   = len_eff;
          data_d  = bus.cmd_data;
          cap_d   = '0;
          mask_d  = MAX_LEN'(1);
          cnt_d   = '0;
          div_d   = '0;
          tck_d   = 1'b0;
          err_d   = ((bus.cmd_op == OP_IR) || (bus.cmd_op == OP_DR)) && (len_eff == '0);
          state_d = ((len_eff == '0) && (bus.cmd_op != OP_RESET)) ? S_RESP : S_PRE;
          load    = 1'b1;
          pin_op  = bus.cmd_op;
          pin_len = len_eff;
        end
      end
      S_PRE, S_SHIFT, S_POST: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + DIV_W'(1);
        end else if (!tck_q) begin
          tck_d = 1'b1;
          div_d = '0;
          if (state_q == S_SHIFT) begin
            cap_d  = cap_q | (tdo ? mask_q : '0);
            mask_d = mask_q << 1;
          end
        end else begin
          // End of a TCK period: falling edge is the only point TMS/TDI may change.
          tck_d = 1'b0;
          div_d = '0;
          load  = 1'b1;
          if (cnt_q == phase_total - LEN_W'(1)) begin
            cnt_d   = '0;
            state_d = phase_next;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
            if (state_q == S_SHIFT) data_d = data_q >> 1;
          end
        end
      end
      S_RESP: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (load) pins_d = pin_bits(state_d, cnt_d, pin_op, pin_len, data_d[0]);
    if (!init_q) pins_d = 3'b100;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      tck_q       <= 1'b0;
      op_q        <= 2'b00;
      len_q       <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      cap_q       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      pins_q      <= 3'b000;
      init_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      tck_q       <= tck_d;
      op_q        <= op_d;
      len_q       <= len_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      cap_q       <= cap_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      pins_q      <= pins_d;
      init_q      <= 1'b1;
    end
  end

  assign tck_o                     = tck_q;
  assign {trstn_o, tms_o, tdi_o}   = pins_q;
  assign busy                      = (state_q != S_IDLE);
  assign bus.rsp_valid             = rsp_valid_q;
  assign bus.rsp_data              = cap_q;
  assign bus.rsp_err               = err_q;
endmodule

// File: tb/tb_jtag_tap_sequencer.sv
// tb/tb_jtag_tap_sequencer.sv - directed self-checking bench for jtag_tap_sequencer with a TAP model
module tb_jtag_tap_sequencer;
  localparam int MAX_LEN = 64, LEN_W = 7, DIV = 2, RST_TCKS = 5;

  typedef enum int {TLR, RTI, SDR, CDR, SHD, E1D, PDR, E2D, UDR,
                    SIR, CIR, SHI, E1I, PIR, E2I, UIR} tap_t;

  logic clk = 1'b0, rst_n = 1'b0, tdo = 1'b0;
  logic busy, tck_o, tms_o, tdi_o, trstn_o;
  int   total = 0, bad = 0, cyc = 0;

  jtag_tap_sequencer_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus();

  jtag_tap_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .TCK_DIV(DIV), .RESET_TCKS(RST_TCKS)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .busy(busy), .tck_o(tck_o),
    .tms_o(tms_o), .tdi_o(tdi_o), .trstn_o(trstn_o), .tdo(tdo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // TAP model: records every TCK rise, follows the IEEE 1149.1 state graph,
  // echoes TDI in Shift-DR and shifts out a 5'b00001 IR capture in Shift-IR.
  logic tms_a [0:1023];
  logic tdi_a [0:1023];
  logic trst_a[0:1023];
  int   rise_cyc[0:1023];
  int   n_rise = 0, last_fall = 0;
  logic [4:0] ir_sr = 5'b0;
  logic tck_prev = 1'b0;
  tap_t tap = TLR;

  function automatic tap_t tap_next(tap_t s, logic m);
    case (s)
      TLR: return m ? TLR : RTI;
      RTI: return m ? SDR : RTI;
      SDR: return m ? SIR : CDR;
      CDR: return m ? E1D : SHD;
      SHD: return m ? E1D : SHD;
      E1D: return m ? UDR : PDR;
      PDR: return m ? E2D : PDR;
      E2D: return m ? UDR : SHD;
      UDR: return m ? SDR : RTI;
      SIR: return m ? TLR : CIR;
      CIR: return m ? E1I : SHI;
      SHI: return m ? E1I : SHI;
      E1I: return m ? UIR : PIR;
      PIR: return m ? E2I : PIR;
      E2I: return m ? UIR : SHI;
      default: return m ? SDR : RTI;
    endcase
  endfunction

  always @(negedge clk) begin
    if (tck_o && !tck_prev && n_rise < 1024) begin
      tms_a[n_rise]    = tms_o;
      tdi_a[n_rise]    = tdi_o;
      trst_a[n_rise]   = trstn_o;
      rise_cyc[n_rise] = cyc;
      if (tap == CIR) ir_sr = 5'b00001;
      else if (tap == SHI) ir_sr = {tdi_o, ir_sr[4:1]};
      tap = tap_next(tap, tms_o);
      n_rise++;
    end
    if (!tck_o && tck_prev) begin
      last_fall = cyc;
      tdo = (tap == SHD) ? tdi_o : ((tap == SHI) ? ir_sr[0] : 1'b0);
    end
    if (!trstn_o) tap = TLR;
    tck_prev = tck_o;
  end

  function automatic logic [127:0] pack(int sel, int b, int n);
    logic [127:0] v = '0;
    for (int i = 0; i < n && i < 128; i++)
      v[i] = (sel == 0) ? tms_a[b+i] : ((sel == 1) ? tdi_a[b+i] : trst_a[b+i]);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  int          base, acc, rsp_cyc, hold_ok, seen_rsp;
  logic [63:0] rdata;
  logic        rerr, got;

  task automatic send(input logic [1:0] op, input logic [LEN_W-1:0] len, input logic [63:0] data);
    base = n_rise;
    bus.cmd_op = op; bus.cmd_len = len; bus.cmd_data = data; bus.cmd_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (bus.cmd_ready) got = 1'b1;
      else step();
    end
    if (got) begin
      @(posedge clk);
      step();
    end
    acc = cyc;
    bus.cmd_valid = 1'b0;
    chk("accept", got, 1'b1);
  endtask

  task automatic wait_rsp(input int max);
    got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      if (bus.rsp_valid) got = 1'b1;
      else step();
    end
    rsp_cyc = cyc;
    rdata   = bus.rsp_data;
    rerr    = bus.rsp_err;
    chk("rsp_seen", got, 1'b1);
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_len = '0; bus.cmd_data = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) step();
    chk("reset_outs", {tck_o, tms_o, tdi_o, trstn_o, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, busy}, 8'h00);
    chk("reset_rsp_data", bus.rsp_data, 0);
    rst_n = 1'b1;
    step();
    chk("post_reset", {trstn_o, bus.cmd_ready}, 2'b11);

    // RESET op
    send(2'b00, 7'd0, 64'h0);
    chk("t1_busy", busy, 1'b1);
    wait_rsp(200);
    chk("t1_tcks", n_rise - base, 6);
    chk("t1_tms", pack(0, base, 6), 6'b011111);
    chk("t1_trstn", pack(2, base, 6), 6'b100000);
    chk("t1_rsp", {rerr, rdata}, 65'h0);
    chk("t1_busy_clr", busy, 1'b0);
    chk("t1_tap", tap, RTI);
    chk("t1_first_low", rise_cyc[base] - acc, DIV);
    chk("t1_period", rise_cyc[base+1] - rise_cyc[base], 2 * DIV);
    chk("t1_rsp_lat", rsp_cyc - last_fall, 1);
    step();

    // SHIFT_DR len 4
    send(2'b10, 7'd4, 64'hB);
    wait_rsp(200);
    chk("t2_tcks", n_rise - base, 9);
    chk("t2_tms", pack(0, base, 9), 9'h0C1);
    chk("t2_tdi", pack(1, base, 9), 9'h058);
    chk("t2_rsp", {rerr, rdata}, {1'b0, 64'hB});
    chk("t2_tap", tap, RTI);
    chk("t2_rsp_lat", rsp_cyc - last_fall, 1);
    step();

    // SHIFT_IR len 5
    send(2'b01, 7'd5, 64'h11);
    wait_rsp(200);
    chk("t3_tcks", n_rise - base, 11);
    chk("t3_tms", pack(0, base, 11), 11'h303);
    chk("t3_tdi", pack(1, base, 11), 11'h110);
    chk("t3_rsp", {rerr, rdata}, {1'b0, 64'h01});
    chk("t3_tap", tap, RTI);
    step();

    // SHIFT_DR len 0 is rejected
    send(2'b10, 7'd0, 64'h5);
    wait_rsp(20);
    chk("t4_zero_tcks", n_rise - base, 0);
    chk("t4_zero_rsp", {rerr, rdata}, {1'b1, 64'h0});
    chk("t4_zero_lat", rsp_cyc - acc, 1);
    step();

    // IDLE len 3 and len 0
    send(2'b11, 7'd3, 64'hFFFF);
    wait_rsp(100);
    chk("idle3_tcks", n_rise - base, 3);
    chk("idle3_pins", {pack(0, base, 3), pack(1, base, 3)}, 0);
    chk("idle3_rsp", {rerr, rdata}, 65'h0);
    step();
    send(2'b11, 7'd0, 64'h0);
    wait_rsp(20);
    chk("idle0_tcks", n_rise - base, 0);
    chk("idle0_rsp", {rerr, rdata}, 65'h0);
    step();

    // len 80 clamps to 64
    send(2'b10, 7'd80, 64'hDEADBEEF_01234567);
    wait_rsp(600);
    chk("clamp_tcks", n_rise - base, 69);
    chk("clamp_tdi", pack(1, base + 3, 64), 64'hDEADBEEF_01234567);
    chk("clamp_rsp", rdata, 64'hDEADBEEF_01234567);
    chk("clamp_tap", tap, RTI);
    step();

    // Response back-pressure, then back-to-back command on release
    bus.rsp_ready = 1'b0;
    send(2'b10, 7'd8, 64'hA5);
    wait_rsp(200);
    chk("t5_rsp", rdata, 64'hA5);
    bus.cmd_op = 2'b11; bus.cmd_len = 7'd2; bus.cmd_data = '0; bus.cmd_valid = 1'b1;
    hold_ok = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.rsp_valid && bus.rsp_data == 64'hA5 && !bus.cmd_ready && !busy) hold_ok++;
    end
    chk("t5_hold", hold_ok, 10);
    chk("t5_no_tck", n_rise - base, 13);
    base = n_rise;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    step();
    chk("t5_release", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    @(posedge clk);
    step();
    acc = cyc;
    bus.cmd_valid = 1'b0;
    chk("t5_b2b_busy", busy, 1'b1);
    wait_rsp(100);
    chk("t5_b2b_tcks", n_rise - base, 2);
    chk("t5_b2b_rsp", {rerr, rdata}, 65'h0);
    step();

    // Reset pulse during shift bit 20 aborts everything
    send(2'b10, 7'd32, 64'hFFFF_FFFF);
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (n_rise - base >= 24) got = 1'b1;
      else step();
    end
    chk("t6_reached", got, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_abort", {tck_o, tms_o, tdi_o, trstn_o, busy, bus.cmd_ready, bus.rsp_valid}, 7'h00);
    repeat (2) step();
    rst_n = 1'b1;
    seen_rsp = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.rsp_valid) seen_rsp++;
    end
    chk("t6_no_rsp", seen_rsp, 0);
    chk("t6_recover", {trstn_o, bus.cmd_ready}, 2'b11);
    send(2'b00, 7'd0, 64'h0);
    wait_rsp(200);
    chk("t6_reset_tap", tap, RTI);
    step();
    send(2'b10, 7'd4, 64'h6);
    wait_rsp(200);
    chk("t6_dr_rsp", rdata, 64'h6);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
